multi_target_hit_detector: RTL and testbench

- Clocked, parametrised successor to the single-ball hit check.
- Tracks N_TARGETS square targets, detects left-click press edges and decides hit or miss.
- On a hit, returns the winning target index and a one-cycle new_ball request.
- Keeps saturating hit/miss counters for the score display, with click lockout and release-wait to reject bounce and held buttons.
- Sits between the mouse decoder and the ball generator / score logic.

---
 rtl/game_pkg.sv | 18 +
 rtl/multi_target_hit_detector_target_hit_check.sv | 30 +++
 rtl/multi_target_hit_detector.sv | 215 +++++++++++++++++++++
 tb/tb_multi_target_hit_detector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: default geometry, screen limits and hit-detector FSM states.
package game_pkg;

  localparam int DEF_N_TARGETS = 4;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_BALL_SIZE = 40;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    LOCKOUT  = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

endpackage

// File: rtl/multi_target_hit_detector_target_hit_check.sv
// Combinational box test of the cursor against one square target; the far edge is
// computed one bit wider so targets near the coordinate limit do not wrap.
module target_hit_check
  import game_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int BALL_SIZE = DEF_BALL_SIZE
) (
  input  logic               valid,
  input  logic [COORD_W-1:0] target_x,
  input  logic [COORD_W-1:0] target_y,
  input  logic [COORD_W-1:0] mouse_x,
  input  logic [COORD_W-1:0] mouse_y,
  output logic               hit
);

  localparam logic [COORD_W:0] BALL_EXT = (COORD_W+1)'(BALL_SIZE);

  logic [COORD_W:0] x_end_s;
  logic [COORD_W:0] y_end_s;
  logic             in_x_s;
  logic             in_y_s;

  assign x_end_s = {1'b0, target_x} + BALL_EXT;
  assign y_end_s = {1'b0, target_y} + BALL_EXT;
  assign in_x_s  = (mouse_x >= target_x) && ({1'b0, mouse_x} < x_end_s);
  assign in_y_s  = (mouse_y >= target_y) && ({1'b0, mouse_y} < y_end_s);
  assign hit     = valid && in_x_s && in_y_s;

endmodule

// File: rtl/multi_target_hit_detector.sv
// Multi-target click hit detector with lockout, release-wait and saturating score counters.
// Optional MIDDLE_DEBUG_EN adds a mouse_middle input that forces a hit on target 0.
module multi_target_hit_detector
  import game_pkg::*;
#(
  parameter int N_TARGETS      = DEF_N_TARGETS,
  parameter int COORD_W        = DEF_COORD_W,
  parameter int BALL_SIZE      = DEF_BALL_SIZE,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int CNT_W          = 16,
  localparam int IDX_W         = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N_TARGETS-1:0]         target_valid,
  input  logic [N_TARGETS*COORD_W-1:0] target_x,
  input  logic [N_TARGETS*COORD_W-1:0] target_y,
  input  logic [COORD_W-1:0]           mouse_x,
  input  logic [COORD_W-1:0]           mouse_y,
  input  logic                         mouse_left,
`ifdef MIDDLE_DEBUG_EN
  input  logic                         mouse_middle,
`endif
  output logic                         hit_pulse,
  output logic [IDX_W-1:0]             hit_idx,
  output logic                         miss_pulse,
  output logic                         new_ball,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count,
  output logic                         busy
);

  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic left_meta_r, left_sync_r, left_prev_r, start_prev_r;
  logic left_click_s, mid_click_s;
  logic [N_TARGETS-1:0] hit_vec_s;
  logic                 any_hit_s;
  logic [IDX_W-1:0]     win_idx_s;

  state_e            state_r, state_nx_s;
  logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_nx_s;
  logic              hit_pulse_r, hit_pulse_nx_s, miss_pulse_r, miss_pulse_nx_s;
  logic              new_ball_r, new_ball_nx_s, busy_r, busy_nx_s;
  logic [IDX_W-1:0]  hit_idx_r, hit_idx_nx_s;
  logic [CNT_W-1:0]  hit_cnt_r, hit_cnt_nx_s, miss_cnt_r, miss_cnt_nx_s;

  // Synchronise the raw left button and keep edge history for it and for start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_meta_r  <= 1'b0;
      left_sync_r  <= 1'b0;
      left_prev_r  <= 1'b0;
      start_prev_r <= 1'b0;
    end else begin
      left_meta_r  <= mouse_left;
      left_sync_r  <= left_meta_r;
      left_prev_r  <= left_sync_r;
      start_prev_r <= start;
    end
  end

  assign left_click_s = left_sync_r & ~left_prev_r;

`ifdef MIDDLE_DEBUG_EN
  logic mid_meta_r, mid_sync_r, mid_prev_r;

  // Synchronise the debug middle button and keep its edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_meta_r <= 1'b0;
      mid_sync_r <= 1'b0;
      mid_prev_r <= 1'b0;
    end else begin
      mid_meta_r <= mouse_middle;
      mid_sync_r <= mid_meta_r;
      mid_prev_r <= mid_sync_r;
    end
  end

  assign mid_click_s = mid_sync_r & ~mid_prev_r;
`else
  assign mid_click_s = 1'b0;
`endif

  for (genvar i = 0; i < N_TARGETS; i++) begin : g_tgt
    target_hit_check #(
      .COORD_W  (COORD_W),
      .BALL_SIZE(BALL_SIZE)
    ) u_chk (
      .valid   (target_valid[i]),
      .target_x(target_x[i*COORD_W +: COORD_W]),
      .target_y(target_y[i*COORD_W +: COORD_W]),
      .mouse_x (mouse_x),
      .mouse_y (mouse_y),
      .hit     (hit_vec_s[i])
    );
  end

  assign any_hit_s = |hit_vec_s;

  // Lowest-index hit wins: scan downwards so lower indices overwrite higher ones
  always_comb begin
    win_idx_s = {IDX_W{1'b0}};
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      win_idx_s = hit_vec_s[i] ? IDX_W'(i) : win_idx_s;
    end
  end

  // Next-state and next-output logic; a low start overrides every state
  always_comb begin
    state_nx_s      = state_r;
    lock_cnt_nx_s   = lock_cnt_r;
    hit_pulse_nx_s  = 1'b0;
    miss_pulse_nx_s = 1'b0;
    new_ball_nx_s   = 1'b0;
    hit_idx_nx_s    = hit_idx_r;
    hit_cnt_nx_s    = hit_cnt_r;
    miss_cnt_nx_s   = miss_cnt_r;
    if (!start) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!start_prev_r) begin
            hit_cnt_nx_s  = {CNT_W{1'b0}};
            miss_cnt_nx_s = {CNT_W{1'b0}};
            state_nx_s    = ARMED;
          end else begin
            state_nx_s = IDLE;
          end
        end
        ARMED: begin
          if (mid_click_s) begin
            hit_pulse_nx_s = 1'b1;
            new_ball_nx_s  = 1'b1;
            hit_idx_nx_s   = {IDX_W{1'b0}};
            lock_cnt_nx_s  = LOCK_LOAD;
            state_nx_s     = LOCKOUT;
          end else if (left_click_s) begin
            if (any_hit_s) begin
              hit_pulse_nx_s = 1'b1;
              new_ball_nx_s  = 1'b1;
              hit_idx_nx_s   = win_idx_s;
              hit_cnt_nx_s   = sat_inc(hit_cnt_r);
            end else begin
              miss_pulse_nx_s = 1'b1;
              miss_cnt_nx_s   = sat_inc(miss_cnt_r);
            end
            lock_cnt_nx_s = LOCK_LOAD;
            state_nx_s    = LOCKOUT;
          end else begin
            state_nx_s = ARMED;
          end
        end
        LOCKOUT: begin
          if (lock_cnt_r == {LOCK_W{1'b0}}) begin
            state_nx_s = WAIT_REL;
          end else begin
            lock_cnt_nx_s = lock_cnt_r - LOCK_W'(1);
          end
        end
        WAIT_REL: begin
          if (!left_sync_r) begin
            state_nx_s = ARMED;
          end else begin
            state_nx_s = WAIT_REL;
          end
        end
        default: state_nx_s = IDLE;
      endcase
    end
    busy_nx_s = (state_nx_s == LOCKOUT) || (state_nx_s == WAIT_REL);
  end

  // State, lockout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      lock_cnt_r   <= {LOCK_W{1'b0}};
      hit_pulse_r  <= 1'b0;
      miss_pulse_r <= 1'b0;
      new_ball_r   <= 1'b0;
      busy_r       <= 1'b0;
      hit_idx_r    <= {IDX_W{1'b0}};
      hit_cnt_r    <= {CNT_W{1'b0}};
      miss_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      lock_cnt_r   <= lock_cnt_nx_s;
      hit_pulse_r  <= hit_pulse_nx_s;
      miss_pulse_r <= miss_pulse_nx_s;
      new_ball_r   <= new_ball_nx_s;
      busy_r       <= busy_nx_s;
      hit_idx_r    <= hit_idx_nx_s;
      hit_cnt_r    <= hit_cnt_nx_s;
      miss_cnt_r   <= miss_cnt_nx_s;
    end
  end

  assign hit_pulse  = hit_pulse_r;
  assign miss_pulse = miss_pulse_r;
  assign new_ball   = new_ball_r;
  assign busy       = busy_r;
  assign hit_idx    = hit_idx_r;
  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;

endmodule

// File: tb/tb_multi_target_hit_detector.sv
// Scoreboard bench for multi_target_hit_detector: a reference model queues expected strobes,
// a monitor pops and compares them whenever the DUT strobes.
module tb_multi_target_hit_detector;

  localparam int NT   = 4;
  localparam int CW   = 10;
  localparam int BS   = 40;
  localparam int LK   = 1000;
  localparam int CNTW = 4;
  localparam int IW   = 2;
  localparam int SAT  = (1 << CNTW) - 1;

  logic             clk = 1'b0;
  logic             rst_n, start, mouse_left;
  logic [NT-1:0]    target_valid;
  logic [NT*CW-1:0] target_x, target_y;
  logic [CW-1:0]    mouse_x, mouse_y;
  logic             hit_pulse, miss_pulse, new_ball, busy;
  logic [IW-1:0]    hit_idx;
  logic [CNTW-1:0]  hit_count, miss_count;

  multi_target_hit_detector #(
    .N_TARGETS(NT), .COORD_W(CW), .BALL_SIZE(BS), .LOCKOUT_CYCLES(LK), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_valid(target_valid),
    .target_x(target_x), .target_y(target_y), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_left(mouse_left), .hit_pulse(hit_pulse), .hit_idx(hit_idx),
    .miss_pulse(miss_pulse), .new_ball(new_ball), .hit_count(hit_count),
    .miss_count(miss_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_hit;
    int idx;
    int hc;
    int mc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   tx[NT], ty[NT];
  bit   tv[NT];
  int   m_hits = 0, m_miss = 0, m_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_targets();
    for (int i = 0; i < NT; i++) begin
      target_x[i*CW +: CW] = CW'(tx[i]);
      target_y[i*CW +: CW] = CW'(ty[i]);
      target_valid[i]      = tv[i];
    end
  endtask

  task automatic set_target(input int i, input int x, input int y, input bit v);
    tx[i] = x;
    ty[i] = y;
    tv[i] = v;
    apply_targets();
  endtask

  // Reference: plain integer box test, first matching index wins, -1 for a miss
  function automatic int ref_hit(input int mx, input int my);
    for (int i = 0; i < NT; i++) begin
      if (tv[i] && mx >= tx[i] && mx < tx[i] + BS && my >= ty[i] && my < ty[i] + BS) return i;
    end
    return -1;
  endfunction

  task automatic push_expected(input int mx, input int my);
    exp_t e;
    int   w;
    w = ref_hit(mx, my);
    if (w >= 0) begin
      m_hits = (m_hits < SAT) ? m_hits + 1 : SAT;
      m_idx  = w;
    end else begin
      m_miss = (m_miss < SAT) ? m_miss + 1 : SAT;
    end
    e.is_hit = (w >= 0);
    e.idx    = m_idx;
    e.hc     = m_hits;
    e.mc     = m_miss;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("busy_release", int'(busy), 0);
  endtask

  // Counted click: push expectation, press for hold cycles, wait for the strobe
  task automatic click(input int mx, input int my, input int hold, input bit to_idle);
    int k = 0;
    @(negedge clk);
    mouse_x = CW'(mx);
    mouse_y = CW'(my);
    push_expected(mx, my);
    mouse_left = 1'b1;
    repeat (hold) @(negedge clk);
    mouse_left = 1'b0;
    while (exp_q.size() != 0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("strobe_timeout", exp_q.size(), 0);
    exp_q.delete();
    check("busy_after_strobe", int'(busy), 1);
    if (to_idle) wait_idle();
  endtask

  task automatic click_ignored(input int mx, input int my);
    @(negedge clk);
    mouse_x    = CW'(mx);
    mouse_y    = CW'(my);
    mouse_left = 1'b1;
    repeat (3) @(negedge clk);
    mouse_left = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst_n && (hit_pulse || miss_pulse || new_ball)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'(hit_pulse | miss_pulse | new_ball), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hit_pulse", int'(hit_pulse), int'(mon_e.is_hit));
        check("miss_pulse", int'(miss_pulse), int'(!mon_e.is_hit));
        check("new_ball", int'(new_ball), int'(mon_e.is_hit));
        check("hit_idx", int'(hit_idx), mon_e.idx);
        check("hit_count", int'(hit_count), mon_e.hc);
        check("miss_count", int'(miss_count), mon_e.mc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mouse_left = 1'b0;
    mouse_x = '0; mouse_y = '0;
    for (int i = 0; i < NT; i++) begin
      tx[i] = 0; ty[i] = 0; tv[i] = 1'b0;
    end
    apply_targets();
    #13;
    check("rst_hit_pulse", int'(hit_pulse), 0);
    check("rst_miss_pulse", int'(miss_pulse), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hit_count", int'(hit_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);

    // Edge behaviour of a single target
    set_target(0, 100, 100, 1'b1);
    click(120, 120, 3, 1'b1);
    click(100, 100, 3, 1'b1);
    click(139, 139, 3, 1'b1);
    click(140, 120, 3, 1'b1);
    check("miss_count_after_edge", int'(miss_count), 1);

    // Asynchronous reset in the middle of lockout
    click(120, 120, 3, 1'b0);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_hit_count", int'(hit_count), 0);
    check("mid_rst_miss_count", int'(miss_count), 0);
    check("mid_rst_hit_idx", int'(hit_idx), 0);
    m_hits = 0; m_miss = 0; m_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    click(120, 120, 3, 1'b1);

    // No valid targets is a miss
    set_target(0, 100, 100, 1'b0);
    click(120, 120, 3, 1'b1);

    // Overlap priority and right-edge / wrap-around targets
    set_target(0, 400, 50, 1'b1);
    set_target(1, 190, 190, 1'b1);
    set_target(2, 620, 300, 1'b1);
    set_target(3, 180, 185, 1'b1);
    click(200, 200, 3, 1'b1);
    click(639, 310, 3, 1'b1);
    set_target(3, 1000, 0, 1'b1);
    click(1020, 10, 3, 1'b1);
    click(1023, 39, 3, 1'b1);

    // Second press inside lockout is ignored
    click(410, 60, 3, 1'b0);
    repeat (4) @(negedge clk);
    click_ignored(410, 60);
    wait_idle();
    repeat (10) @(negedge clk);

    // Held button: one strobe, then re-arm after release
    click(410, 60, 2000, 1'b1);
    click(410, 60, 3, 1'b1);

    // Hit counter saturation
    for (int i = 0; i < 20; i++) click(410, 60, 3, 1'b1);
    check("hit_count_sat", int'(hit_count), SAT);

    // start low: clicks ignored, counters hold; re-rise clears them
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    click_ignored(410, 60);
    check("hold_hit_count", int'(hit_count), SAT);
    check("hold_miss_count", int'(miss_count), m_miss);
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("restart_hit_count", int'(hit_count), 0);
    check("restart_miss_count", int'(miss_count), 0);
    m_hits = 0; m_miss = 0;

    // Randomised targets and cursor positions near a chosen target
    for (int r = 0; r < 12; r++) begin
      int t, mx, my;
      for (int i = 0; i < NT; i++) begin
        tx[i] = int'($urandom_range(0, 1023));
        ty[i] = int'($urandom_range(0, 1023));
        tv[i] = ($urandom_range(0, 3) != 0);
      end
      apply_targets();
      t  = int'($urandom_range(0, NT - 1));
      mx = tx[t] + int'($urandom_range(0, 49)) - 5;
      my = ty[t] + int'($urandom_range(0, 49)) - 5;
      mx = (mx < 0) ? 0 : ((mx > 1023) ? 1023 : mx);
      my = (my < 0) ? 0 : ((my > 1023) ? 1023 : my);
      click(mx, my, int'($urandom_range(1, 6)), 1'b1);
    end

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
